// File: rtl/dual_port_ram_be.sv
// True dual-port synchronous RAM with per-byte write enables and registered, valid-flagged reads.
// After every reset the whole array is cleared by hardware before any port access is accepted.
module dual_port_ram_be #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   din_a,
    output logic [DATA_W-1:0]   dout_a,
    output logic                vld_a,
    input  logic                en_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   din_b,
    output logic [DATA_W-1:0]   dout_b,
    output logic                vld_b,
    output logic                busy,
    output logic                collision
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                run;
    logic                wr_a, wr_b;
    logic [DATA_W-1:0]   merged_a, merged_b;
    logic [DATA_W-1:0]   dout_a_q, dout_b_q;
    logic                vld_a_q, vld_b_q, collision_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == S_CLEAR) begin
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == '1) begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        run  = (state_q == S_RUN);
        busy = (state_q == S_CLEAR);
    end

    assign wr_a = run && en_a && we_a;
    assign wr_b = run && en_b && we_b;

    // Word as it will look after this port's byte merge; only used for write-first readback.
    always_comb begin
        merged_a = mem[addr_a];
        merged_b = mem[addr_b];
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (be_a[i]) merged_a[8*i +: 8] = din_a[8*i +: 8];
            if (be_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
        end
    end

    // Port A writes are issued last so that A wins on bytes both ports enable.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_ptr_q] <= '0;
        end else begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            end
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q    <= '0;
            dout_b_q    <= '0;
            vld_a_q     <= 1'b0;
            vld_b_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            vld_a_q     <= run && en_a;
            vld_b_q     <= run && en_b;
            collision_q <= wr_a && wr_b && (addr_a == addr_b) && ((be_a & be_b) != '0);
            if (run && en_a) begin
                dout_a_q <= (RDW_MODE == 1 && we_a) ? merged_a : mem[addr_a];
            end
            if (run && en_b) begin
                dout_b_q <= (RDW_MODE == 1 && we_b) ? merged_b : mem[addr_b];
            end
        end
    end

    assign dout_a    = dout_a_q;
    assign dout_b    = dout_b_q;
    assign vld_a     = vld_a_q;
    assign vld_b     = vld_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: one read-first and one write-first instance share all inputs.
module tb_dual_port_ram_be;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en_a, we_a, en_b, we_b;
    logic [1:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic          vld_a0, vld_b0, vld_a1, vld_b1;
    logic          busy0, busy1, coll0, coll1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a0), .vld_a(vld_a0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b0), .vld_b(vld_b0),
        .busy(busy0), .collision(coll0)
    );

    dual_port_ram_be #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a1), .vld_a(vld_a1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b1), .vld_b(vld_b1),
        .busy(busy1), .collision(coll1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 0; we_a = 0; be_a = 2'b00; addr_a = '0; din_a = '0;
        en_b = 0; we_b = 0; be_b = 2'b00; addr_b = '0; din_b = '0;
    endtask

    task automatic port_a(input logic we, input logic [1:0] be, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din);
        en_a = 1; we_a = we; be_a = be; addr_a = addr; din_a = din;
    endtask

    task automatic port_b(input logic we, input logic [1:0] be, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din);
        en_b = 1; we_b = we; be_b = be; addr_b = addr; din_b = din;
    endtask

    // Releases reset and counts cycles until busy falls, with port A hammering address 0 meanwhile.
    task automatic run_clear(input string tag);
        int  n;
        int  vld_seen;
        n = 0;
        vld_seen = 0;
        port_a(1'b1, 2'b11, 6'h00, 16'hFFFF);
        rst_n = 1;
        while (n < 200) begin
            tick();
            n++;
            if (vld_a0 || vld_a1) vld_seen++;
            if (!busy0 && !busy1) break;
        end
        idle();
        total++;
        if (n !== 64) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d expected 64", tag, n);
        end
        total++;
        if (vld_seen !== 0) begin
            bad++;
            $display("FAIL %s_vld_during_clear: got %0d cycles with vld expected 0", tag, vld_seen);
        end
    endtask

    task automatic test_reset();
        int errs;
        idle();
        rst_n = 0;
        #3;
        total++;
        if ({dout_a0, dout_b0, vld_a0, vld_b0, coll0, busy0} !== {16'h0, 16'h0, 4'b0001}) begin
            bad++;
            $display("FAIL reset_outputs: got %h %h %b%b%b%b expected 0000 0000 0001",
                     dout_a0, dout_b0, vld_a0, vld_b0, coll0, busy0);
        end
        tick();
        tick();
        run_clear("reset");
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            port_a(1'b0, 2'b00, AW'(i), '0);
            port_b(1'b0, 2'b00, AW'(63 - i), '0);
            tick();
            if (dout_a0 !== 16'h0 || dout_b0 !== 16'h0 || dout_a1 !== 16'h0 || !vld_a0 || !vld_b0)
                errs++;
        end
        idle();
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL reset_clear_readback: got %0d nonzero/invalid reads expected 0", errs);
        end
    endtask

    task automatic test_cross_read();
        port_a(1'b1, 2'b11, 6'h01, 16'h1234);
        tick();
        idle();
        port_b(1'b0, 2'b00, 6'h01, '0);
        tick();
        idle();
        total++;
        if (dout_b0 !== 16'h1234 || vld_b0 !== 1'b1) begin
            bad++;
            $display("FAIL cross_read: got dout_b=%h vld_b=%b expected 1234 1", dout_b0, vld_b0);
        end
        total++;
        if (vld_a0 !== 1'b0 || dout_a1 !== 16'h1234) begin
            bad++;
            $display("FAIL idle_hold: got vld_a=%b dout_a(wf)=%h expected 0 1234", vld_a0, dout_a1);
        end
    endtask

    task automatic test_byte_enable();
        port_a(1'b1, 2'b11, 6'h02, 16'hABCD);
        tick();
        port_a(1'b1, 2'b10, 6'h02, 16'hFF00);
        tick();
        total++;
        if (dout_a0 !== 16'hABCD || dout_a1 !== 16'hFFCD) begin
            bad++;
            $display("FAIL partial_write_rdw: got rf=%h wf=%h expected ABCD FFCD", dout_a0, dout_a1);
        end
        port_a(1'b0, 2'b00, 6'h02, '0);
        tick();
        idle();
        total++;
        if (dout_a0 !== 16'hFFCD || dout_a1 !== 16'hFFCD) begin
            bad++;
            $display("FAIL byte_lane_keep: got rf=%h wf=%h expected FFCD FFCD", dout_a0, dout_a1);
        end
    endtask

    task automatic test_rdw();
        port_a(1'b1, 2'b11, 6'h03, 16'h1111);
        tick();
        port_a(1'b1, 2'b11, 6'h03, 16'h2222);
        port_b(1'b0, 2'b00, 6'h03, '0);
        tick();
        idle();
        total++;
        if (dout_a0 !== 16'h1111) begin
            bad++;
            $display("FAIL rdw_read_first: got %h expected 1111", dout_a0);
        end
        total++;
        if (dout_a1 !== 16'h2222) begin
            bad++;
            $display("FAIL rdw_write_first: got %h expected 2222", dout_a1);
        end
        total++;
        if (dout_b0 !== 16'h1111 || dout_b1 !== 16'h1111) begin
            bad++;
            $display("FAIL rdw_cross_old: got rf=%h wf=%h expected 1111 1111", dout_b0, dout_b1);
        end
        // B writes while A reads: A still sees the old word
        port_b(1'b1, 2'b11, 6'h03, 16'h0BEE);
        port_a(1'b0, 2'b00, 6'h03, '0);
        tick();
        idle();
        total++;
        if (dout_a0 !== 16'h2222 || dout_a1 !== 16'h2222 || dout_b1 !== 16'h0BEE) begin
            bad++;
            $display("FAIL rdw_b_write_a_read: got a=%h/%h b(wf)=%h expected 2222/2222 0BEE",
                     dout_a0, dout_a1, dout_b1);
        end
    endtask

    task automatic test_collision();
        port_a(1'b1, 2'b11, 6'h04, 16'hAAAA);
        port_b(1'b1, 2'b11, 6'h04, 16'h5555);
        tick();
        idle();
        total++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
            bad++;
            $display("FAIL collision_pulse: got %b%b expected 11", coll0, coll1);
        end
        port_a(1'b0, 2'b00, 6'h04, '0);
        tick();
        idle();
        total++;
        if (coll0 !== 1'b0 || dout_a0 !== 16'hAAAA) begin
            bad++;
            $display("FAIL collision_a_wins: got coll=%b mem=%h expected 0 AAAA", coll0, dout_a0);
        end
        port_a(1'b1, 2'b01, 6'h04, 16'hAAAA);
        port_b(1'b1, 2'b10, 6'h04, 16'h5555);
        tick();
        idle();
        total++;
        if (coll0 !== 1'b0) begin
            bad++;
            $display("FAIL collision_disjoint: got %b expected 0", coll0);
        end
        port_b(1'b0, 2'b00, 6'h04, '0);
        tick();
        idle();
        total++;
        if (dout_b0 !== 16'h55AA) begin
            bad++;
            $display("FAIL disjoint_merge: got %h expected 55AA", dout_b0);
        end
    endtask

    task automatic test_reset_mid_clear();
        port_a(1'b1, 2'b11, 6'h05, 16'h7777);
        tick();
        port_a(1'b0, 2'b00, 6'h05, '0);
        tick();
        idle();
        total++;
        if (dout_a0 !== 16'h7777) begin
            bad++;
            $display("FAIL pre_reset_write: got %h expected 7777", dout_a0);
        end
        rst_n = 0;
        #1;
        total++;
        if (dout_a0 !== 16'h0 || vld_a0 !== 1'b0 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got dout=%h vld=%b busy=%b expected 0000 0 1",
                     dout_a0, vld_a0, busy0);
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 0;
        #1;
        total++;
        if (busy0 !== 1'b1 || vld_b0 !== 1'b0 || coll0 !== 1'b0) begin
            bad++;
            $display("FAIL mid_clear_reset: got busy=%b vld_b=%b coll=%b expected 1 0 0",
                     busy0, vld_b0, coll0);
        end
        tick();
        run_clear("restart");
        port_a(1'b0, 2'b00, 6'h05, '0);
        port_b(1'b0, 2'b00, 6'h01, '0);
        tick();
        idle();
        total++;
        if (dout_a0 !== 16'h0 || dout_b0 !== 16'h0 || vld_a0 !== 1'b1) begin
            bad++;
            $display("FAIL post_restart_read: got a=%h b=%h vld=%b expected 0000 0000 1",
                     dout_a0, dout_b0, vld_a0);
        end
    endtask

    initial begin
        test_reset();
        test_cross_read();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
